// File: rtl/uart_pkg.sv
// Shared types for the UART transmit arbiter.
package uart_pkg;

    localparam int unsigned ByteW = 8;

    typedef enum logic [1:0] {
        RESYNC     = 2'd0,
        IDLE       = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } uart_arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans upward from last+1 with wrap, one-hot grant out.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx
);

    localparam int unsigned IdxW = $clog2(N);

    always_comb begin
        int unsigned idx;
        logic        found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned off = 1; off <= N; off++) begin
            idx = (32'(last) + off) % N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx[IdxW-1:0];
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one toggle-triggered UART transmitter among NUM_REQ byte producers.
// Optional start watchdog enabled by defining UART_TX_ARB_WDOG_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned WDOG_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [ByteW*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [ByteW-1:0]           uart_data,
    output logic                       uart_send,
    input  logic                       uart_sending,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       wdog_err
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);

    uart_arb_state_e state_q, state_d;
    logic [IdxW-1:0]  last_q, last_d;
    logic [IdxW-1:0]  gid_q, gid_d;
    logic [ByteW-1:0] data_q, data_d;
    logic             send_q, send_d;
    logic             quiet_q, quiet_d;

    logic [NUM_REQ-1:0] gnt;
    logic [IdxW-1:0]    gnt_idx;
    logic [ByteW-1:0]   win_byte;

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_rr_arbiter (
        .req     (req_valid),
        .last    (last_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        win_byte = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) win_byte = req_data[ByteW*i +: ByteW];
        end
    end

`ifdef UART_TX_ARB_WDOG_EN
    localparam int unsigned CntW = $clog2(WDOG_CYCLES + 1);
    logic [CntW-1:0] wcnt_q, wcnt_d;
    logic            wdog_q, wdog_d;
`else
    logic unused_wdog_cfg;
    assign unused_wdog_cfg = ^WDOG_CYCLES;
`endif

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        gid_d     = gid_q;
        data_d    = data_q;
        send_d    = send_q;
        quiet_d   = quiet_q;
        req_ready = '0;
`ifdef UART_TX_ARB_WDOG_EN
        wcnt_d    = wcnt_q;
        wdog_d    = 1'b0;
`endif
        unique case (state_q)
            // The transmitter may be draining a frame started by our reset edge on uart_send.
            RESYNC: begin
                if (!uart_sending) begin
                    quiet_d = 1'b1;
                    if (quiet_q) state_d = IDLE;
                end else begin
                    quiet_d = 1'b0;
                end
            end
            IDLE: begin
                req_ready = gnt;
                if (|gnt) begin
                    data_d  = win_byte;
                    send_d  = ~send_q;
                    last_d  = gnt_idx;
                    gid_d   = gnt_idx;
                    state_d = WAIT_START;
`ifdef UART_TX_ARB_WDOG_EN
                    wcnt_d  = '0;
`endif
                end
            end
            WAIT_START: begin
                if (uart_sending) begin
                    state_d = WAIT_DONE;
                end
`ifdef UART_TX_ARB_WDOG_EN
                else if (wcnt_q == CntW'(WDOG_CYCLES - 1)) begin
                    wdog_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
`endif
            end
            WAIT_DONE: begin
                if (!uart_sending) state_d = IDLE;
            end
            default: state_d = RESYNC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESYNC;
            last_q  <= IdxW'(NUM_REQ - 1);
            gid_q   <= '0;
            data_q  <= '0;
            send_q  <= 1'b0;
            quiet_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gid_q   <= gid_d;
            data_q  <= data_d;
            send_q  <= send_d;
            quiet_q <= quiet_d;
        end
    end

`ifdef UART_TX_ARB_WDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q <= '0;
            wdog_q <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            wdog_q <= wdog_d;
        end
    end
    assign wdog_err = wdog_q;
`else
    assign wdog_err = 1'b0;
`endif

    assign uart_data = data_q;
    assign uart_send = send_q;
    assign grant_id  = gid_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a toggle-triggered UART transmitter model (16 clk/bit).
// Watchdog checks follow UART_TX_ARB_WDOG_EN.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic [7:0]  uart_data;
    logic        uart_send;
    logic        uart_sending;
    logic [1:0]  grant_id;
    logic        busy;
    logic        wdog_err;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ     (4),
        .WDOG_CYCLES (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .uart_data    (uart_data),
        .uart_send    (uart_send),
        .uart_sending (uart_sending),
        .grant_id     (grant_id),
        .busy         (busy),
        .wdog_err     (wdog_err)
    );

    // Transmitter model: no reset, starts a frame on any uart_send edge while idle.
    logic       prev_send = 1'b0;
    logic       sending_m = 1'b0;
    logic       quiet = 1'b0;
    logic [9:0] sh = '0;
    logic [9:0] rxf = '0;
    logic [3:0] tick = '0;
    logic [3:0] bitn = '0;
    logic [7:0] quiet_run = '0;
    logic       tx;
    logic [9:0] rxq[$];

    assign tx           = sending_m ? sh[0] : 1'b1;
    assign uart_sending = sending_m;

    always @(posedge clk) begin
        prev_send <= uart_send;
        quiet_run <= sending_m ? 8'd0 : (quiet_run == 8'hFF ? quiet_run : quiet_run + 8'd1);
        if (sending_m) begin
            if (tick == 4'd7) begin
                rxf[bitn] <= tx;
                if (bitn == 4'd9) rxq.push_back({tx, rxf[8:0]});
            end
            if (tick == 4'd15) begin
                tick <= '0;
                if (bitn == 4'd9) sending_m <= 1'b0;
                else begin
                    bitn <= bitn + 4'd1;
                    sh   <= sh >> 1;
                end
            end else begin
                tick <= tick + 4'd1;
            end
        end else if (!quiet && uart_send != prev_send) begin
            sending_m <= 1'b1;
            sh        <= {1'b1, uart_data, 1'b0};
            tick      <= '0;
            bitn      <= '0;
        end
    end

    int n_vec = 0;
    int n_err = 0;
    logic       pend = 1'b0;
    logic [7:0] pend_byte = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Wait at negedges until IDLE, then check the serial frame of the previous grant.
    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", {31'd0, busy}, 32'd0);
        if (pend) begin
            pend = 1'b0;
            if (rxq.size() == 0) chk("rx_frame_present", 32'd0, 32'd1);
            else chk("rx_frame", {22'd0, rxq.pop_front()}, {22'd0, 1'b1, pend_byte, 1'b0});
        end
    endtask

    task automatic apply(input logic [3:0] v, input logic [31:0] d, input logic [3:0] er,
                         input logic [1:0] eg, input logic [7:0] eb);
        logic s0;
        wait_idle(1000);
        req_valid = v;
        req_data  = d;
        s0        = uart_send;
        #1;
        chk("ready", {28'd0, req_ready}, {28'd0, er});
        @(negedge clk);
        chk("grant_id", {30'd0, grant_id}, {30'd0, eg});
        chk("uart_data", {24'd0, uart_data}, {24'd0, eb});
        chk("send_toggle", {31'd0, uart_send}, {31'd0, ~s0});
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        pend      = 1'b1;
        pend_byte = eb;
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  exp_ready;
        logic [1:0]  exp_gid;
        logic [7:0]  exp_byte;
    } vec_t;

    localparam logic [31:0] D = 32'h13121110;

    initial begin
        vec_t tbl[12];
        int   n;
        tbl[0]  = '{4'b0001, 32'h000000A5, 4'b0001, 2'd0, 8'hA5};
        tbl[1]  = '{4'b1111, D, 4'b0010, 2'd1, 8'h11};
        tbl[2]  = '{4'b1111, D, 4'b0100, 2'd2, 8'h12};
        tbl[3]  = '{4'b1111, D, 4'b1000, 2'd3, 8'h13};
        tbl[4]  = '{4'b1111, D, 4'b0001, 2'd0, 8'h10};
        tbl[5]  = '{4'b1111, D, 4'b0010, 2'd1, 8'h11};
        tbl[6]  = '{4'b0100, D, 4'b0100, 2'd2, 8'h12};
        tbl[7]  = '{4'b0100, D, 4'b0100, 2'd2, 8'h12};
        tbl[8]  = '{4'b1001, D, 4'b1000, 2'd3, 8'h13};
        tbl[9]  = '{4'b1001, D, 4'b0001, 2'd0, 8'h10};
        tbl[10] = '{4'b0110, D, 4'b0010, 2'd1, 8'h11};
        tbl[11] = '{4'b1010, D, 4'b1000, 2'd3, 8'h13};

        // Reset values, with a requester already waiting.
        req_valid = 4'b0001;
        req_data  = 32'h000000A5;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_send", {31'd0, uart_send}, 32'd0);
        chk("rst_data", {24'd0, uart_data}, 32'd0);
        chk("rst_gid", {30'd0, grant_id}, 32'd0);
        chk("rst_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_wdog", {31'd0, wdog_err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("resync_busy_1", {31'd0, busy}, 32'd1);
        chk("resync_ready_1", {28'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("resync_busy_2", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            apply(tbl[i].valid, tbl[i].data, tbl[i].exp_ready, tbl[i].exp_gid, tbl[i].exp_byte);
        end

        // Valid pulse while busy is dropped and must not move the rotation pointer.
        apply(4'b0010, D, 4'b0010, 2'd1, 8'h11);
        req_valid = 4'b0100;
        repeat (5) begin
            @(negedge clk);
            chk("pulse_ready", {28'd0, req_ready}, 32'd0);
        end
        req_valid = 4'b0000;
        wait_idle(1000);
        repeat (3) begin
            @(negedge clk);
            chk("no_valid_idle", {31'd0, busy}, 32'd0);
        end
        apply(4'b1111, D, 4'b0100, 2'd2, 8'h12);

        // Reset mid-frame with all requesters waiting.
        apply(4'b0001, D, 4'b0001, 2'd0, 8'h10);
        req_valid = 4'b1111;
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_busy", {31'd0, busy}, 32'd1);
            chk("midrst_send", {31'd0, uart_send}, 32'd0);
            chk("midrst_gid", {30'd0, grant_id}, 32'd0);
            chk("midrst_ready", {28'd0, req_ready}, 32'd0);
        end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("resync_hold_busy", {31'd0, busy}, 32'd1);
        chk("resync_hold_ready", {28'd0, req_ready}, 32'd0);
        n = 0;
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("resync_done", {31'd0, busy}, 32'd0);
        chk("resync_quiet_run", {24'd0, quiet_run}, 32'd2);
        pend = 1'b0;
        rxq.delete();
        apply(4'b1111, D, 4'b0001, 2'd0, 8'h10);
        apply(4'b1111, D, 4'b0010, 2'd1, 8'h11);
        apply(4'b1111, D, 4'b0100, 2'd2, 8'h12);
        apply(4'b1111, D, 4'b1000, 2'd3, 8'h13);
        apply(4'b1111, D, 4'b0001, 2'd0, 8'h10);
        req_valid = 4'b0000;
        wait_idle(1000);

        // Transmitter never starts.
        quiet     = 1'b1;
        req_valid = 4'b0001;
        @(negedge clk);
        req_valid = 4'b0000;
        chk("stall_accept_busy", {31'd0, busy}, 32'd1);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
`ifdef UART_TX_ARB_WDOG_EN
            if (k >= 14 && k <= 18) begin
                chk("wdog_pulse", {31'd0, wdog_err}, {31'd0, k == 16});
                chk("wdog_busy", {31'd0, busy}, {31'd0, k < 16});
            end
`else
            if (k == 16 || k == 40) begin
                chk("stall_busy", {31'd0, busy}, 32'd1);
                chk("stall_wdog", {31'd0, wdog_err}, 32'd0);
            end
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
